// File: rtl/multiplier_pkg.sv
// Shared constants for the two-pass RV32M multiplier sequencer:
// funct3 codes, one-hot state encoding and the fixed operation latency.
package multiplier_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    // Cycles from acceptance to done_o.
    localparam int unsigned MUL_LAT = 5;

    typedef enum logic [5:0] {
        StIdle  = 6'b000001,
        StRot   = 6'b000010,
        StP2    = 6'b000100,
        StAcc   = 6'b001000,
        StDrain = 6'b010000,
        StDone  = 6'b100000
    } state_e;

endpackage

// File: rtl/multiplier_ctrl.sv
// Sequencing controller for the two-pass 32x32 multiplier datapath: accepts a request,
// decodes funct3 and drives the per-cycle datapath strobes until the result is ready.
module multiplier_ctrl
    import multiplier_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             ac_clr_o,
    output logic             reg_A_en_o,
    output logic             reg_B_en_o,
    output logic             en_pipe_o,
    output logic             AC_en_o,
    output logic             mux_B_sel_o,
    output logic             rol_en_o,
    output logic             shift_amount_o,
    output logic             upper_o,
    output logic             signed_A_o,
    output logic             signed_B_o
);

    state_e           state_q, state_d;
    logic [TAG_W-1:0] tag_q;
    logic             accept;
    logic             unused_funct3_msb;

    assign unused_funct3_msb = funct3_i[2];

    assign accept = start_i && !flush_i && ((state_q == StIdle) || (state_q == StDone));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tag_q <= tag_i;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ac_clr_o       = 1'b0;
        reg_A_en_o     = 1'b0;
        reg_B_en_o     = 1'b0;
        en_pipe_o      = 1'b0;
        AC_en_o        = 1'b0;
        mux_B_sel_o    = 1'b0;
        rol_en_o       = 1'b0;
        shift_amount_o = 1'b0;
        upper_o        = 1'b0;
        signed_A_o     = 1'b0;
        signed_B_o     = 1'b0;

        if (flush_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StRot: begin
                    // Pass 1 enters the pipe while B is rotated for pass 2.
                    reg_B_en_o  = 1'b1;
                    mux_B_sel_o = 1'b1;
                    rol_en_o    = 1'b1;
                    en_pipe_o   = 1'b1;
                    state_d     = StP2;
                end
                StP2: begin
                    en_pipe_o      = 1'b1;
                    shift_amount_o = 1'b1;
                    AC_en_o        = 1'b1;
                    state_d        = StAcc;
                end
                StAcc: begin
                    en_pipe_o = 1'b1;
                    AC_en_o   = 1'b1;
                    state_d   = StDrain;
                end
                StDrain: begin
                    // AC_en low here clears the datapath's piped accumulate enable.
                    en_pipe_o = 1'b1;
                    state_d   = StDone;
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase

            if (accept) begin
                reg_A_en_o  = 1'b1;
                reg_B_en_o  = 1'b1;
                ac_clr_o    = 1'b1;
                mux_B_sel_o = 1'b0;
                rol_en_o    = 1'b0;
                upper_o     = (funct3_i[1:0] != F3_MUL[1:0]);
                signed_A_o  = (funct3_i[1:0] == F3_MULH[1:0]) ||
                              (funct3_i[1:0] == F3_MULHSU[1:0]);
                signed_B_o  = (funct3_i[1:0] == F3_MULH[1:0]);
                state_d     = StRot;
            end
        end
    end

    assign busy_o = (state_q == StRot) || (state_q == StP2) ||
                    (state_q == StAcc) || (state_q == StDrain);
    assign done_o = (state_q == StDone) && !flush_i;
    assign tag_o  = tag_q;

endmodule

// File: tb/tb_multiplier_ctrl.sv
// Bench for multiplier_ctrl: a behavioural two-pass datapath driven by the strobes,
// with a queue of expected results checked whenever done_o is presented.
module tb_multiplier_ctrl;
    import multiplier_pkg::*;

    localparam int unsigned TAG_W = 5;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
        int               cyc;
    } exp_t;

    logic             clk_i    = 1'b0;
    logic             rst_i    = 1'b1;
    logic             start_i  = 1'b0;
    logic             flush_i  = 1'b0;
    logic [2:0]       funct3_i = 3'b000;
    logic [TAG_W-1:0] tag_i    = '0;
    logic [31:0]      op_a     = '0;
    logic [31:0]      op_b     = '0;

    logic             busy_o, done_o;
    logic [TAG_W-1:0] tag_o;
    logic             ac_clr_o, reg_A_en_o, reg_B_en_o, en_pipe_o, AC_en_o;
    logic             mux_B_sel_o, rol_en_o, shift_amount_o;
    logic             upper_o, signed_A_o, signed_B_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    // Expected strobes ROT..DONE, bit order as in strobes() below.
    localparam logic [12:0] SCHED [5] = '{
        13'b1000110110000,
        13'b1000011001000,
        13'b1000011000000,
        13'b1000010000000,
        13'b0100000000000
    };

    multiplier_ctrl #(
        .TAG_W(TAG_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .funct3_i      (funct3_i),
        .tag_i         (tag_i),
        .flush_i       (flush_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .tag_o         (tag_o),
        .ac_clr_o      (ac_clr_o),
        .reg_A_en_o    (reg_A_en_o),
        .reg_B_en_o    (reg_B_en_o),
        .en_pipe_o     (en_pipe_o),
        .AC_en_o       (AC_en_o),
        .mux_B_sel_o   (mux_B_sel_o),
        .rol_en_o      (rol_en_o),
        .shift_amount_o(shift_amount_o),
        .upper_o       (upper_o),
        .signed_A_o    (signed_A_o),
        .signed_B_o    (signed_B_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Pass 0: lo*lo + hi*hi<<32. Pass 1 (B rotated): cross terms <<16.
    function automatic logic [63:0] pass_sum(input logic [31:0] a, input logic [31:0] b,
                                             input logic sh, input logic sa, input logic sb_s);
        longint al, ah, bl, bh;
        al = longint'(a[15:0]);
        ah = sa ? longint'($signed(a[31:16])) : longint'(a[31:16]);
        if (!sh) begin
            bl = longint'(b[15:0]);
            bh = sb_s ? longint'($signed(b[31:16])) : longint'(b[31:16]);
            return (al * bl) + ((ah * bh) <<< 32);
        end
        bh = sb_s ? longint'($signed(b[15:0])) : longint'(b[15:0]);
        bl = longint'(b[31:16]);
        return ((al * bh) + (ah * bl)) <<< 16;
    endfunction

    logic [31:0] a_q, b_q;
    logic        up_q, sa_q, sb_q, ac_en_q;
    logic [63:0] s1_q, s2_q, acc_q;
    logic [31:0] dp_res;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q <= '0; b_q <= '0; up_q <= 1'b0; sa_q <= 1'b0; sb_q <= 1'b0;
            s1_q <= '0; s2_q <= '0; acc_q <= '0; ac_en_q <= 1'b0;
        end else begin
            if (reg_A_en_o) begin
                a_q <= op_a; up_q <= upper_o; sa_q <= signed_A_o; sb_q <= signed_B_o;
            end
            if (reg_B_en_o) b_q <= (mux_B_sel_o && rol_en_o) ? {b_q[15:0], b_q[31:16]} : op_b;
            if (en_pipe_o) begin
                s1_q <= pass_sum(a_q, b_q, shift_amount_o, sa_q, sb_q);
                s2_q <= s1_q;
            end
            ac_en_q <= AC_en_o;
            if (ac_clr_o)     acc_q <= '0;
            else if (ac_en_q) acc_q <= acc_q + s2_q;
        end
    end

    assign dp_res = up_q ? acc_q[63:32] : acc_q[31:0];

    function automatic logic [31:0] strobes();
        return {19'd0, busy_o, done_o, ac_clr_o, reg_A_en_o, reg_B_en_o, en_pipe_o, AC_en_o,
                mux_B_sel_o, rol_en_o, shift_amount_o, upper_o, signed_A_o, signed_B_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drives one request for a cycle; dec = expected {upper, signed_A, signed_B}.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input logic [2:0] dec, input bit push,
                         input logic [31:0] res);
        exp_t e;
        start_i  = 1'b1;
        funct3_i = f3;
        tag_i    = tag;
        op_a     = a;
        op_b     = b;
        @(negedge clk_i);
        check("accept_en", {29'd0, ac_clr_o, reg_A_en_o, reg_B_en_o}, 32'd7);
        check("accept_rot", {30'd0, mux_B_sel_o, rol_en_o}, 32'd0);
        check("decode", {29'd0, upper_o, signed_A_o, signed_B_o}, {29'd0, dec});
        if (push) begin
            e.tag = tag;
            e.res = res;
            e.cyc = cyc + int'(MUL_LAT);
            sb.push_back(e);
        end
        step();
        start_i  = 1'b0;
        funct3_i = 3'b000;
        tag_i    = ~tag;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        check("done_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && done_o) begin
            exp_t e;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done_o), 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_tag", 32'(tag_o), 32'(e.tag));
                check("result", dp_res, e.res);
                check("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_i);
        check("reset_strobes", strobes(), 32'd0);
        check("reset_tag", 32'(tag_o), 32'd0);
        step();
        rst_i = 1'b0;
        step();

        // MULHU all-ones with full schedule check.
        issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 3'b100, 1'b1, 32'hFFFF_FFFE);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check($sformatf("sched%0d", i), strobes(), {19'd0, SCHED[i]});
            step();
        end
        @(negedge clk_i);
        check("tag_hold", 32'(tag_o), 32'd7);
        check("idle_strobes", strobes(), 32'd0);
        step();

        // Back-to-back: second request accepted in DONE.
        issue(F3_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd1, 3'b000, 1'b1, 32'h242D_2080);
        repeat (4) step();
        issue(F3_MULH, 32'hFFFF_FFFE, 32'h0000_0003, 5'd2, 3'b111, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk_i);
        check("b2b_busy", 32'(busy_o), 32'd1);
        step();
        wait_done();

        issue(F3_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 3'b110, 1'b1, 32'h8000_0000);
        wait_done();

        // Start pulsed in P2 is ignored.
        issue(F3_MULHU, 32'h0001_0000, 32'h0001_0000, 5'd4, 3'b100, 1'b1, 32'h0000_0001);
        step();
        start_i  = 1'b1;
        funct3_i = F3_MULH;
        tag_i    = 5'd9;
        @(negedge clk_i);
        check("busy_start_strobes", strobes(), {19'd0, SCHED[1]});
        check("busy_start_tag", 32'(tag_o), 32'd4);
        step();
        start_i = 1'b0;
        @(negedge clk_i);
        check("busy_start_tag_next", 32'(tag_o), 32'd4);
        step();
        wait_done();

        // Flush in ACC: strobes gated, no done.
        issue(F3_MUL, 32'd3, 32'd5, 5'd5, 3'b000, 1'b0, 32'd0);
        step();
        step();
        flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_gate", strobes(), 32'h0000_1000);
        step();
        flush_i = 1'b0;
        @(negedge clk_i);
        check("flush_idle", strobes(), 32'd0);
        repeat (8) step();

        // Flush beats a simultaneous start.
        start_i = 1'b1;
        flush_i = 1'b1;
        tag_i   = 5'd11;
        @(negedge clk_i);
        check("flush_vs_start", strobes(), 32'd0);
        step();
        start_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk_i);
        check("flush_no_accept", strobes(), 32'd0);
        check("flush_no_capture", 32'(tag_o), 32'd5);
        step();
        issue(F3_MUL, 32'd3, 32'd5, 5'd6, 3'b000, 1'b1, 32'd15);
        wait_done();

        // Reset asserted in ROT.
        issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 3'b100, 1'b0, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_strobes", strobes(), 32'd0);
        check("rst_tag", 32'(tag_o), 32'd0);
        step();
        rst_i = 1'b0;
        step();
        issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 3'b100, 1'b1, 32'hFFFF_FFFE);
        wait_done();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
